// File: rtl/e203_exu_longp_retire_pkg.sv
// Shared widths and the holding-entry record for the long-pipe retire stage.
package e203_exu_longp_retire_pkg;

    localparam int LONGP_ITAG_W   = 1;
    localparam int LONGP_ITAG_MAX = 8;
    localparam int RDIDX_W        = 5;
    localparam int XLEN           = 32;

    // itag is stored zero-extended to LONGP_ITAG_MAX so one record serves any ITAG_W
    typedef struct packed {
        logic [LONGP_ITAG_MAX-1:0] itag;
        logic [XLEN-1:0]           wdat;
        logic                      err;
        logic [XLEN-1:0]           badaddr;
    } longp_ent_t;

endpackage

// File: rtl/e203_exu_longp_retire_ent.sv
// Single completion holding entry: capture, drain, ready and retire-pointer match.
module e203_exu_longp_ent
    import e203_exu_longp_retire_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      i_valid,
    output logic                      i_ready,
    input  longp_ent_t                i_ent,
    input  logic [LONGP_ITAG_MAX-1:0] ret_ptr,
    input  logic                      oitf_empty,
    input  logic                      drain,
    output logic                      vld,
    output longp_ent_t                ent,
    output logic                      match
);

    logic capture;

    assign i_ready = ~vld | drain;
    assign capture = i_valid & i_ready;
    assign match   = vld & (ent.itag == ret_ptr) & ~oitf_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld <= 1'b0;
            ent <= '0;
        end else begin
            if (capture) begin
                vld <= 1'b1;
                ent <= i_ent;
            end else if (drain) begin
                vld <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/e203_exu_longp_retire.sv
// Long-pipe in-order retire: LSU entry always, NICE entry when E203_LONGP_NICE_EN is defined.
module e203_exu_longp_retire
    import e203_exu_longp_retire_pkg::*;
#(
    parameter int ITAG_W = LONGP_ITAG_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                lsu_i_valid,
    output logic                lsu_i_ready,
    input  logic [ITAG_W-1:0]   lsu_i_itag,
    input  logic [XLEN-1:0]     lsu_i_wdat,
    input  logic                lsu_i_err,
    input  logic [XLEN-1:0]     lsu_i_badaddr,
`ifdef E203_LONGP_NICE_EN
    input  logic                nice_i_valid,
    output logic                nice_i_ready,
    input  logic [ITAG_W-1:0]   nice_i_itag,
    input  logic [XLEN-1:0]     nice_i_wdat,
    input  logic                nice_i_err,
`endif
    input  logic                oitf_empty,
    input  logic [ITAG_W-1:0]   oitf_ret_ptr,
    input  logic [RDIDX_W-1:0]  oitf_ret_rdidx,
    input  logic                oitf_ret_rdwen,
    input  logic                oitf_ret_rdfpu,
    input  logic [XLEN-1:0]     oitf_ret_pc,
    output logic                oitf_ret_ena,
    output logic                wbck_o_valid,
    input  logic                wbck_o_ready,
    output logic [XLEN-1:0]     wbck_o_wdat,
    output logic [RDIDX_W-1:0]  wbck_o_rdidx,
    output logic                wbck_o_rdfpu,
    output logic                excp_o_valid,
    input  logic                excp_o_ready,
    output logic [XLEN-1:0]     excp_o_pc,
    output logic [XLEN-1:0]     excp_o_badaddr,
    output logic                excp_o_src_nice
);

    logic [LONGP_ITAG_MAX-1:0] ret_ptr_ext;
    longp_ent_t                lsu_in, lsu_ent, nice_ent, sel_ent;
    logic                      lsu_vld, lsu_match, sel_lsu, sel_nice, sel_any;
    logic                      retire;

    assign ret_ptr_ext = LONGP_ITAG_MAX'(oitf_ret_ptr);

    assign lsu_in = '{itag: LONGP_ITAG_MAX'(lsu_i_itag), wdat: lsu_i_wdat,
                      err: lsu_i_err, badaddr: lsu_i_badaddr};

    e203_exu_longp_ent u_lsu_ent (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_valid    (lsu_i_valid),
        .i_ready    (lsu_i_ready),
        .i_ent      (lsu_in),
        .ret_ptr    (ret_ptr_ext),
        .oitf_empty (oitf_empty),
        .drain      (retire & sel_lsu),
        .vld        (lsu_vld),
        .ent        (lsu_ent),
        .match      (lsu_match)
    );

`ifdef E203_LONGP_NICE_EN
    longp_ent_t nice_in;
    logic       nice_vld, nice_match;

    assign nice_in = '{itag: LONGP_ITAG_MAX'(nice_i_itag), wdat: nice_i_wdat,
                       err: nice_i_err, badaddr: '0};

    e203_exu_longp_ent u_nice_ent (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_valid    (nice_i_valid),
        .i_ready    (nice_i_ready),
        .i_ent      (nice_in),
        .ret_ptr    (ret_ptr_ext),
        .oitf_empty (oitf_empty),
        .drain      (retire & sel_nice),
        .vld        (nice_vld),
        .ent        (nice_ent),
        .match      (nice_match)
    );

    assign sel_nice = nice_match & ~lsu_match;

    // Two live entries carrying the same tag means the tracking FIFO was corrupted upstream
    a_no_dual_match : assert property (@(posedge clk) disable iff (!rst_n)
        !(lsu_match && nice_match));
`else
    assign nice_ent = '0;
    assign sel_nice = 1'b0;
`endif

    assign sel_lsu = lsu_match;
    assign sel_any = sel_lsu | sel_nice;
    assign sel_ent = sel_lsu ? lsu_ent : nice_ent;

    assign excp_o_valid = sel_any & sel_ent.err;
    assign wbck_o_valid = sel_any & ~sel_ent.err & oitf_ret_rdwen;

    // Stores (no rd write, no error) retire without any downstream handshake
    always_comb begin
        retire = 1'b0;
        if (sel_any) begin
            if (sel_ent.err)         retire = excp_o_ready;
            else if (oitf_ret_rdwen) retire = wbck_o_ready;
            else                     retire = 1'b1;
        end
    end

    assign oitf_ret_ena = retire;

    assign wbck_o_wdat     = wbck_o_valid ? sel_ent.wdat   : '0;
    assign wbck_o_rdidx    = wbck_o_valid ? oitf_ret_rdidx : '0;
    assign wbck_o_rdfpu    = wbck_o_valid & oitf_ret_rdfpu;
    assign excp_o_pc       = excp_o_valid ? oitf_ret_pc     : '0;
    assign excp_o_badaddr  = excp_o_valid ? sel_ent.badaddr : '0;
    assign excp_o_src_nice = excp_o_valid & sel_nice;

    logic unused_ok;
    assign unused_ok = ^{lsu_vld};

endmodule

// File: tb/tb_e203_exu_longp_retire.sv
// Directed self-checking bench for the long-pipe retire stage (NICE section runs with E203_LONGP_NICE_EN).
module tb_e203_exu_longp_retire;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        lsu_i_valid, lsu_i_ready, lsu_i_err;
    logic [0:0]  lsu_i_itag;
    logic [31:0] lsu_i_wdat, lsu_i_badaddr;
`ifdef E203_LONGP_NICE_EN
    logic        nice_i_valid, nice_i_ready, nice_i_err;
    logic [0:0]  nice_i_itag;
    logic [31:0] nice_i_wdat;
`endif
    logic        oitf_empty, oitf_ret_rdwen, oitf_ret_rdfpu, oitf_ret_ena;
    logic [0:0]  oitf_ret_ptr;
    logic [4:0]  oitf_ret_rdidx, wbck_o_rdidx;
    logic [31:0] oitf_ret_pc, wbck_o_wdat, excp_o_pc, excp_o_badaddr;
    logic        wbck_o_valid, wbck_o_ready, wbck_o_rdfpu;
    logic        excp_o_valid, excp_o_ready, excp_o_src_nice;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    e203_exu_longp_retire #(.ITAG_W(1)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .lsu_i_valid     (lsu_i_valid),
        .lsu_i_ready     (lsu_i_ready),
        .lsu_i_itag      (lsu_i_itag),
        .lsu_i_wdat      (lsu_i_wdat),
        .lsu_i_err       (lsu_i_err),
        .lsu_i_badaddr   (lsu_i_badaddr),
`ifdef E203_LONGP_NICE_EN
        .nice_i_valid    (nice_i_valid),
        .nice_i_ready    (nice_i_ready),
        .nice_i_itag     (nice_i_itag),
        .nice_i_wdat     (nice_i_wdat),
        .nice_i_err      (nice_i_err),
`endif
        .oitf_empty      (oitf_empty),
        .oitf_ret_ptr    (oitf_ret_ptr),
        .oitf_ret_rdidx  (oitf_ret_rdidx),
        .oitf_ret_rdwen  (oitf_ret_rdwen),
        .oitf_ret_rdfpu  (oitf_ret_rdfpu),
        .oitf_ret_pc     (oitf_ret_pc),
        .oitf_ret_ena    (oitf_ret_ena),
        .wbck_o_valid    (wbck_o_valid),
        .wbck_o_ready    (wbck_o_ready),
        .wbck_o_wdat     (wbck_o_wdat),
        .wbck_o_rdidx    (wbck_o_rdidx),
        .wbck_o_rdfpu    (wbck_o_rdfpu),
        .excp_o_valid    (excp_o_valid),
        .excp_o_ready    (excp_o_ready),
        .excp_o_pc       (excp_o_pc),
        .excp_o_badaddr  (excp_o_badaddr),
        .excp_o_src_nice (excp_o_src_nice)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // Inputs change 1 ns after the rising edge; outputs are sampled 1 ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        rst_n          = 1'b0;
        lsu_i_valid    = 1'b0;
        lsu_i_itag     = 1'b0;
        lsu_i_wdat     = '0;
        lsu_i_err      = 1'b0;
        lsu_i_badaddr  = '0;
`ifdef E203_LONGP_NICE_EN
        nice_i_valid   = 1'b0;
        nice_i_itag    = 1'b0;
        nice_i_wdat    = '0;
        nice_i_err     = 1'b0;
`endif
        oitf_empty     = 1'b0;
        oitf_ret_ptr   = 1'b0;
        oitf_ret_rdidx = 5'd5;
        oitf_ret_rdwen = 1'b1;
        oitf_ret_rdfpu = 1'b0;
        oitf_ret_pc    = 32'h0000_0100;
        wbck_o_ready   = 1'b1;
        excp_o_ready   = 1'b1;

        // Reset state
        #12;
        chk("rst_lsu_ready", lsu_i_ready, 1);
        chk("rst_wbck_valid", wbck_o_valid, 0);
        chk("rst_excp_valid", excp_o_valid, 0);
        chk("rst_ret_ena", oitf_ret_ena, 0);
        chk("rst_wbck_wdat", wbck_o_wdat, 0);
        chk("rst_excp_badaddr", excp_o_badaddr, 0);
        rst_n = 1'b1;
        tick();

        // LSU load
        lsu_i_valid = 1'b1; lsu_i_itag = 1'b0; lsu_i_wdat = 32'h1234_5678;
        settle();
        chk("load_no_bypass_valid", wbck_o_valid, 0);
        chk("load_no_bypass_ena", oitf_ret_ena, 0);
        tick();
        lsu_i_valid = 1'b0;
        settle();
        chk("load_wbck_valid", wbck_o_valid, 1);
        chk("load_wbck_wdat", wbck_o_wdat, 32'h1234_5678);
        chk("load_wbck_rdidx", wbck_o_rdidx, 5);
        chk("load_ret_ena", oitf_ret_ena, 1);
        tick();
        chk("load_after_valid", wbck_o_valid, 0);
        chk("load_after_ena", oitf_ret_ena, 0);

        // Store: no write-back, retires one cycle after capture
        oitf_ret_ptr = 1'b1; oitf_ret_rdwen = 1'b0;
        lsu_i_valid = 1'b1; lsu_i_itag = 1'b1; lsu_i_wdat = 32'hDEAD_BEEF;
        tick();
        lsu_i_valid = 1'b0;
        settle();
        chk("store_ret_ena", oitf_ret_ena, 1);
        chk("store_wbck_valid", wbck_o_valid, 0);
        tick();
        chk("store_after_ena", oitf_ret_ena, 0);

        // Bus error held off by excp_o_ready for 3 cycles
        oitf_ret_ptr = 1'b0; oitf_ret_rdwen = 1'b1; oitf_ret_pc = 32'h0000_2040;
        excp_o_ready = 1'b0;
        lsu_i_valid = 1'b1; lsu_i_itag = 1'b0; lsu_i_err = 1'b1;
        lsu_i_badaddr = 32'h8000_0010; lsu_i_wdat = 32'h0;
        tick();
        lsu_i_valid = 1'b0; lsu_i_err = 1'b0; lsu_i_badaddr = 32'h0;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("err_excp_valid", excp_o_valid, 1);
            chk("err_badaddr", excp_o_badaddr, 32'h8000_0010);
            chk("err_pc", excp_o_pc, 32'h0000_2040);
            chk("err_wbck_valid", wbck_o_valid, 0);
            chk("err_ret_ena_held", oitf_ret_ena, 0);
            chk("err_lsu_ready_held", lsu_i_ready, 0);
            chk("err_src_nice", excp_o_src_nice, 0);
            tick();
        end
        excp_o_ready = 1'b1;
        settle();
        chk("err_ret_ena", oitf_ret_ena, 1);
        chk("err_lsu_ready_drain", lsu_i_ready, 1);
        tick();
        chk("err_after_valid", excp_o_valid, 0);
        chk("err_after_ena", oitf_ret_ena, 0);

        // Streaming tags 0,1,0,1; bench advances ret_ptr on each observed retire
        oitf_ret_ptr = 1'b0; wbck_o_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            lsu_i_valid = (i < 4);
            lsu_i_itag  = 1'(i % 2);
            lsu_i_wdat  = 32'hA000_0000 + 32'(i);
            settle();
            if (i < 4) chk("stream_lsu_ready", lsu_i_ready, 1);
            if (i > 0) begin
                chk("stream_ret_ena", oitf_ret_ena, 1);
                chk("stream_wdat", wbck_o_wdat, 32'hA000_0000 + 32'(i - 1));
            end else begin
                chk("stream_first_ena", oitf_ret_ena, 0);
            end
            tick();
            if (i > 0) oitf_ret_ptr = ~oitf_ret_ptr;
        end
        lsu_i_valid = 1'b0;
        settle();
        chk("stream_idle_ena", oitf_ret_ena, 0);
        chk("stream_ptr_wrapped", 32'(oitf_ret_ptr), 0);

        // Unmatched entry waits until the pointer reaches it
        lsu_i_valid = 1'b1; lsu_i_itag = 1'b1; lsu_i_wdat = 32'h5555_AAAA;
        tick();
        lsu_i_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            settle();
            chk("wait_wbck_valid", wbck_o_valid, 0);
            chk("wait_lsu_ready", lsu_i_ready, 0);
            tick();
        end
        oitf_empty = 1'b1; oitf_ret_ptr = 1'b1;
        settle();
        chk("wait_empty_valid", wbck_o_valid, 0);
        oitf_empty = 1'b0;
        settle();
        chk("wait_match_valid", wbck_o_valid, 1);
        chk("wait_match_wdat", wbck_o_wdat, 32'h5555_AAAA);
        tick();
        oitf_ret_ptr = 1'b0;

`ifdef E203_LONGP_NICE_EN
        // NICE tag 1 arrives first, LSU tag 0 after; LSU must retire first
        nice_i_valid = 1'b1; nice_i_itag = 1'b1; nice_i_wdat = 32'h0000_0E1C;
        tick();
        nice_i_valid = 1'b0;
        lsu_i_valid = 1'b1; lsu_i_itag = 1'b0; lsu_i_wdat = 32'h0000_0150;
        settle();
        chk("ooo_nothing_yet", oitf_ret_ena, 0);
        tick();
        lsu_i_valid = 1'b0;
        settle();
        chk("ooo_lsu_ena", oitf_ret_ena, 1);
        chk("ooo_lsu_wdat", wbck_o_wdat, 32'h0000_0150);
        tick();
        oitf_ret_ptr = 1'b1;
        settle();
        chk("ooo_nice_ena", oitf_ret_ena, 1);
        chk("ooo_nice_wdat", wbck_o_wdat, 32'h0000_0E1C);
        tick();
        oitf_ret_ptr = 1'b0;
        settle();
        chk("ooo_after_ena", oitf_ret_ena, 0);
`endif

        // Reset while waiting on write-back ready
        wbck_o_ready = 1'b0; oitf_ret_rdwen = 1'b1;
        lsu_i_valid = 1'b1; lsu_i_itag = 1'b0; lsu_i_wdat = 32'h7777_0000;
        tick();
        lsu_i_valid = 1'b0;
        settle();
        chk("midrst_pre_valid", wbck_o_valid, 1);
        rst_n = 1'b0;
        settle();
        chk("midrst_wbck_valid", wbck_o_valid, 0);
        chk("midrst_lsu_ready", lsu_i_ready, 1);
        chk("midrst_wdat", wbck_o_wdat, 0);
        tick();
        rst_n = 1'b1;
        wbck_o_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("midrst_no_ena", oitf_ret_ena, 0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "bench time limit reached");
    end

endmodule
